// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared sizes and entry layout for the instruction fetch queue
package inst_fetch_queue_pkg;

    localparam int DEPTH        = 16;
    localparam int PTR_W        = 4;
    localparam int LANES        = 4;
    localparam int IFQ_ENTRY_WD = 97;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_jump;
        logic [31:0] pred_tgt;
    } ifq_entry_t;

    function automatic ifq_entry_t make_entry(input logic [27:0] pc_hi, input logic [1:0] lane,
                                              input logic [31:0] inst, input logic jump,
                                              input logic [31:0] target);
        ifq_entry_t e;
        e.pc        = {pc_hi, lane, 2'b00};
        e.inst      = inst;
        e.pred_jump = jump;
        e.pred_tgt  = jump ? target : 32'h0;
        return e;
    endfunction

endpackage

// File: rtl/ifq_compact.sv
// rtl/ifq_compact.sv - packs the valid lanes of a fetch group into consecutive output slots
module ifq_compact
    import inst_fetch_queue_pkg::*;
(
    input  logic [3:0]      mask,
    output logic [2:0]      n,
    output logic [3:0][1:0] sel
);

    // Slot k takes the k-th set lane in ascending lane order; unused slots stay 0.
    always_comb begin
        n   = '0;
        sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                sel[n[1:0]] = 2'(i);
                n           = n + 3'd1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - 4-wide in, 2-wide out instruction fetch queue; IFQ_STAT_EN adds stall/empty counters
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         fs_valid,
    output logic         fs_ready,
    input  logic [31:0]  fs_pc,
    input  logic [127:0] fs_inst,
    input  logic [3:0]   fs_valid_mask,
    input  logic [3:0]   fs_is_jump,
    input  logic [31:0]  fs_pred_target,
    output logic         ds_valid1,
    output logic         ds_valid2,
    output logic [31:0]  ds_pc1,
    output logic [31:0]  ds_pc2,
    output logic [31:0]  ds_inst1,
    output logic [31:0]  ds_inst2,
    output logic         ds_pred_jump1,
    output logic         ds_pred_jump2,
    output logic [31:0]  ds_pred_tgt1,
    output logic [31:0]  ds_pred_tgt2,
    input  logic         ds_pop1,
    input  logic         ds_pop2
`ifdef IFQ_STAT_EN
    ,
    output logic [31:0]  stat_full_cyc,
    output logic [31:0]  stat_empty_cyc
`endif
);

    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [PTR_W:0]          count;
    logic [IFQ_ENTRY_WD-1:0] mem [DEPTH];

    logic [2:0]              n_lanes;
    logic [3:0][1:0]         sel;
    logic [2:0]              n_enq;
    logic [1:0]              n_pop;
    logic                    enq;
    logic                    pop1;
    logic                    pop2;
    ifq_entry_t              lane_entry [LANES];
    ifq_entry_t              e1;
    ifq_entry_t              e2;
    logic                    unused_pc_low;

    assign unused_pc_low = ^fs_pc[3:0];

    ifq_compact u_compact (
        .mask (fs_valid_mask),
        .n    (n_lanes),
        .sel  (sel)
    );

    // Credit comes only from the registered count; same-cycle pops are not counted.
    assign fs_ready  = count <= (PTR_W+1)'(DEPTH - LANES);
    assign enq       = fs_valid & fs_ready & ~flush;
    assign n_enq     = enq ? n_lanes : 3'd0;

    assign ds_valid1 = count != '0;
    assign ds_valid2 = count >= (PTR_W+1)'(2);
    assign pop1      = ds_pop1 & ds_valid1;
    assign pop2      = ds_pop1 & ds_pop2 & ds_valid2;
    assign n_pop     = {1'b0, pop1} + {1'b0, pop2};

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_entry[i] = make_entry(fs_pc[31:4], 2'(i), fs_inst[32*i +: 32],
                                       fs_is_jump[i], fs_pred_target);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            for (int k = 0; k < LANES; k++) begin
                if (3'(k) < n_lanes) begin
                    mem[tail + PTR_W'(k)] <= lane_entry[sel[k]];
                end
            end
        end
    end

    // Head reads come straight from storage, so a new group is visible one cycle after enqueue.
    assign e1 = ifq_entry_t'(mem[head]);
    assign e2 = ifq_entry_t'(mem[head + PTR_W'(1)]);

    assign ds_pc1        = e1.pc;
    assign ds_inst1      = e1.inst;
    assign ds_pred_jump1 = e1.pred_jump;
    assign ds_pred_tgt1  = e1.pred_tgt;
    assign ds_pc2        = e2.pc;
    assign ds_inst2      = e2.inst;
    assign ds_pred_jump2 = e2.pred_jump;
    assign ds_pred_tgt2  = e2.pred_tgt;

`ifdef IFQ_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_full_cyc  <= '0;
            stat_empty_cyc <= '0;
        end else begin
            if (fs_valid && !fs_ready && stat_full_cyc != 32'hffffffff)
                stat_full_cyc <= stat_full_cyc + 32'd1;
            if (count == '0 && stat_empty_cyc != 32'hffffffff)
                stat_empty_cyc <= stat_empty_cyc + 32'd1;
        end
    end
`endif

    a_pop2_needs_pop1: assert property (@(posedge clk) disable iff (reset) !(ds_pop2 && !ds_pop1));

endmodule
